// File: rtl/scan_sequencer.sv
// scan_sequencer: raster-scan coordinate generator for the Mandelbrot datapath.
// Walks an H_PIX x V_PIX grid row by row and offers one (x, y) per valid/ready
// transfer, flagging row ends (line_tick) and frame completion (frame_done).
//
// Ports:
//   clk, reset     rising-edge clock, asynchronous active-low reset
//   clk_en         global enable; 0 freezes every register
//   start          level; launches a frame when seen in IDLE
//   pause          blocks transfers (same effect as out_ready low)
//   out_ready      downstream accepts the coordinate
//   out_valid, x, y  coordinate offer
//   line_tick      pulse after the last pixel of a row transfers
//   frame_done     pulse after the final pixel of the frame transfers
//   busy           high in RUN and DONE
//   frame_cnt      completed frames, modulo 2^FW
module scan_sequencer #(
    parameter int unsigned XW    = 10,
    parameter int unsigned YW    = 10,
    parameter int unsigned H_PIX = 640,
    parameter int unsigned V_PIX = 480,
    parameter int unsigned FW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clk_en,
    input  logic          start,
    input  logic          pause,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          line_tick,
    output logic          frame_done,
    output logic          busy,
    output logic [FW-1:0] frame_cnt
);

    localparam logic [XW-1:0] X_LAST = XW'(H_PIX - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_PIX - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [FW-1:0] r_frame_cnt;
    logic          r_valid;
    logic          r_line_tick;
    logic          r_frame_done;
    logic          r_busy;

    state_t        w_state_nx;
    logic [XW-1:0] w_x_nx;
    logic [YW-1:0] w_y_nx;
    logic [FW-1:0] w_frame_cnt_nx;
    logic          w_line_tick_nx;
    logic          w_frame_done_nx;
    logic          w_xfer;

    assign w_xfer = clk_en & r_valid & out_ready & ~pause;

    // State register; every register freezes while clk_en is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_x          <= '0;
            r_y          <= '0;
            r_frame_cnt  <= '0;
            r_valid      <= 1'b0;
            r_line_tick  <= 1'b0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
        end else if (clk_en) begin
            r_state      <= w_state_nx;
            r_x          <= w_x_nx;
            r_y          <= w_y_nx;
            r_frame_cnt  <= w_frame_cnt_nx;
            r_valid      <= (w_state_nx == S_RUN);
            r_line_tick  <= w_line_tick_nx;
            r_frame_done <= w_frame_done_nx;
            r_busy       <= (w_state_nx != S_IDLE);
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nx      = r_state;
        w_x_nx          = r_x;
        w_y_nx          = r_y;
        w_frame_cnt_nx  = r_frame_cnt;
        w_line_tick_nx  = 1'b0;
        w_frame_done_nx = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_x_nx = '0;
                w_y_nx = '0;
                if (start) begin
                    w_state_nx = S_RUN;
                end
            end
            S_RUN: begin
                if (w_xfer) begin
                    if (r_x != X_LAST) begin
                        w_x_nx = r_x + XW'(1);
                    end else if (r_y != Y_LAST) begin
                        w_x_nx         = '0;
                        w_y_nx         = r_y + YW'(1);
                        w_line_tick_nx = 1'b1;
                    end else begin
                        // Last pixel: coordinate stays put until DONE clears it.
                        w_state_nx      = S_DONE;
                        w_line_tick_nx  = 1'b1;
                        w_frame_done_nx = 1'b1;
                    end
                end
            end
            S_DONE: begin
                w_frame_cnt_nx = r_frame_cnt + FW'(1);
                w_x_nx         = '0;
                w_y_nx         = '0;
                w_state_nx     = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    assign out_valid  = r_valid;
    assign x          = r_x;
    assign y          = r_y;
    assign line_tick  = r_line_tick;
    assign frame_done = r_frame_done;
    assign busy       = r_busy;
    assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_scan_sequencer.sv
// Self-checking bench for scan_sequencer on a 4x3 grid with a 2-bit frame
// counter. Expected coordinates are queued when a frame is launched and
// compared as the DUT transfers them; pulse outputs are predicted from the
// queued coordinates.
module tb_scan_sequencer;

    localparam int unsigned XW = 4;
    localparam int unsigned YW = 4;
    localparam int unsigned H  = 4;
    localparam int unsigned V  = 3;
    localparam int unsigned FW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          clk_en = 1'b1;
    logic          start = 1'b0;
    logic          pause = 1'b0;
    logic          out_ready = 1'b1;
    logic          out_valid;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          line_tick;
    logic          frame_done;
    logic          busy;
    logic [FW-1:0] frame_cnt;

    scan_sequencer #(
        .XW(XW), .YW(YW), .H_PIX(H), .V_PIX(V), .FW(FW)
    ) dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .start(start),
        .pause(pause), .out_ready(out_ready), .out_valid(out_valid),
        .x(x), .y(y), .line_tick(line_tick), .frame_done(frame_done),
        .busy(busy), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int x;
        int y;
        bit last;
    } coord_t;

    coord_t exp_q[$];

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic push_frame();
        coord_t c;
        for (int j = 0; j < int'(V); j++) begin
            for (int i = 0; i < int'(H); i++) begin
                c.x = i;
                c.y = j;
                c.last = (i == int'(H) - 1) && (j == int'(V) - 1);
                exp_q.push_back(c);
            end
        end
    endtask

    // Monitor: scoreboard compare on each transfer, pulse and hold prediction.
    bit     m_lt;
    bit     m_fd;
    int     m_cnt;
    bit     prev_hold;
    int     prev_x;
    int     prev_y;
    bit     mon_xfer;
    coord_t mon_e;

    always @(negedge clk) begin
        if (!reset) begin
            m_lt      = 1'b0;
            m_fd      = 1'b0;
            m_cnt     = 0;
            prev_hold = 1'b0;
        end else begin
            check("line_tick", int'(line_tick), int'(m_lt));
            check("frame_done", int'(frame_done), int'(m_fd));
            check("frame_cnt", int'(frame_cnt), m_cnt);
            if (prev_hold) begin
                check("hold_valid", int'(out_valid), 1);
                check("hold_x", int'(x), prev_x);
                check("hold_y", int'(y), prev_y);
            end
            mon_xfer  = clk_en && out_valid && out_ready && !pause;
            prev_hold = out_valid && !mon_xfer;
            prev_x    = int'(x);
            prev_y    = int'(y);
            if (clk_en) begin
                if (m_fd) m_cnt = (m_cnt + 1) % (1 << FW);
                m_lt = 1'b0;
                m_fd = 1'b0;
                if (mon_xfer) begin
                    if (exp_q.size() == 0) begin
                        check("xfer_unexpected", 1, 0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("sb_x", int'(x), mon_e.x);
                        check("sb_y", int'(y), mon_e.y);
                        m_lt = (mon_e.x == int'(H) - 1);
                        m_fd = mon_e.last;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Sample until (xx, yy) is offered; ends on a negedge.
    task automatic wait_xy(input int xx, input int yy);
        int n = 0;
        do begin
            sample();
            n++;
        end while (!(out_valid && int'(x) == xx && int'(y) == yy) && n < 200);
        if (!(out_valid && int'(x) == xx && int'(y) == yy)) check("wait_xy_timeout", 0, 1);
    endtask

    // Sample until frame_done; returns samples taken and line_tick count.
    task automatic wait_fd(output int cyc, output int lts);
        cyc = 0;
        lts = 0;
        do begin
            sample();
            cyc++;
            if (line_tick) lts++;
        end while (!frame_done && cyc < 200);
        if (!frame_done) check("fd_timeout", 0, 1);
    endtask

    task automatic launch();
        push_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    int cyc;
    int lts;
    int g;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        tick();
        check("rst_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_cnt", int'(frame_cnt), 0);
        tick();
        reset = 1'b1;
        repeat (3) begin
            sample();
            check("idle_valid", int'(out_valid), 0);
            check("idle_busy", int'(busy), 0);
            check("idle_x", int'(x), 0);
        end

        // Full-rate frame with latency and line_tick count
        tick();
        push_frame();
        start = 1'b1;
        sample();
        check("lat_pre_valid", int'(out_valid), 0);
        tick();
        start = 1'b0;
        sample();
        check("lat_valid", int'(out_valid), 1);
        check("lat_busy", int'(busy), 1);
        check("first_x", int'(x), 0);
        check("first_y", int'(y), 0);
        wait_fd(cyc, lts);
        check("frame_len", cyc, 12);
        check("line_ticks", lts, 3);
        check("done_busy", int'(busy), 1);
        check("done_valid", int'(out_valid), 0);
        sample();
        check("cnt_after_f1", int'(frame_cnt), 1);
        check("idle_busy2", int'(busy), 0);

        // Backpressure at (2,1)
        tick();
        launch();
        wait_xy(1, 1);
        tick();
        out_ready = 1'b0;
        repeat (5) begin
            sample();
            check("bp_valid", int'(out_valid), 1);
            check("bp_x", int'(x), 2);
            check("bp_y", int'(y), 1);
            tick();
        end
        out_ready = 1'b1;
        sample();
        tick();
        sample();
        check("bp_next_x", int'(x), 3);
        check("bp_next_y", int'(y), 1);
        wait_fd(cyc, lts);
        check("bp_q_empty", exp_q.size(), 0);

        // Pause, then clk_en hold while line_tick is high
        tick();
        launch();
        wait_xy(1, 0);
        tick();
        pause = 1'b1;
        repeat (3) begin
            sample();
            check("pause_x", int'(x), 2);
            check("pause_y", int'(y), 0);
            tick();
        end
        pause = 1'b0;
        wait_xy(3, 0);
        tick();
        clk_en = 1'b0;
        repeat (4) begin
            sample();
            check("ce_line_tick", int'(line_tick), 1);
            check("ce_x", int'(x), 0);
            check("ce_y", int'(y), 1);
            check("ce_valid", int'(out_valid), 1);
            tick();
        end
        clk_en = 1'b1;
        wait_fd(cyc, lts);
        check("ce_q_empty", exp_q.size(), 0);
        sample();
        check("cnt_after_f3", int'(frame_cnt), 3);

        // Asynchronous reset mid-frame
        tick();
        launch();
        wait_xy(2, 1);
        tick();
        reset = 1'b0;
        exp_q.delete();
        #1;
        check("arst_x", int'(x), 0);
        check("arst_y", int'(y), 0);
        check("arst_valid", int'(out_valid), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_cnt", int'(frame_cnt), 0);
        tick();
        reset = 1'b1;
        repeat (6) begin
            sample();
            check("post_rst_valid", int'(out_valid), 0);
            check("post_rst_busy", int'(busy), 0);
        end

        // Continuous start: 2-cycle gaps and frame_cnt wrap
        tick();
        for (int f = 0; f < 4; f++) push_frame();
        start = 1'b1;
        for (int f = 0; f < 4; f++) begin
            wait_fd(cyc, lts);
            if (f == 3) begin
                tick();
                start = 1'b0;
                sample();
                check("wrap_cnt", int'(frame_cnt), 0);
                check("wrap_idle_valid", int'(out_valid), 0);
                sample();
                check("wrap_stop_valid", int'(out_valid), 0);
            end else begin
                g = 1;
                for (int n = 0; n < 50; n++) begin
                    sample();
                    if (n == 0) check("cont_cnt", int'(frame_cnt), (f + 1) % 4);
                    if (out_valid) break;
                    g++;
                end
                check("cont_gap", g, 2);
            end
        end
        check("cont_q_empty", exp_q.size(), 0);

        // start pulsed during RUN is ignored
        tick();
        launch();
        wait_xy(1, 1);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_fd(cyc, lts);
        check("ign_q_empty", exp_q.size(), 0);
        sample();
        check("ign_cnt", int'(frame_cnt), 1);
        repeat (3) begin
            sample();
            check("ign_no_restart", int'(out_valid), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
